pwm_reg_scheduler: RTL and testbench
====================================

# pwm_reg_scheduler

Update scheduler between the SPI register-write decode and the PWM output stage. Accepts single-cycle register writes into shadow registers, then commits them to the active configuration only at a PWM period boundary, or on an explicit force request. Active registers therefore never change mid-period, which prevents duty-cycle and mode glitches. Also owns the PWM prescaler and the 8-bit period counter that define those boundaries.

## Interface
- DIV, default 4: prescaler ratio; one PWM tick every DIV clk cycles. Legal range 1..65535.
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  single-cycle write strobe from the SPI decode
- wr_addr  in  7  register address: 0x00 en_out[7:0], 0x01 en_out[15:8], 0x02 en_pwm_mode[7:0], 0x03 en_pwm_mode[15:8], 0x04 pwm_duty_cycle
- wr_data  in  8  write data
- commit_now  in  1  single-cycle force-commit request
- en_out  out  16  active output-enable register
- en_pwm_mode  out  16  active PWM-mode register
- pwm_duty_cycle  out  8  active duty cycle
- pwm_cnt  out  8  PWM period counter
- period_start  out  1  high for the first clk cycle of each period
- pending  out  1  at least one shadow register is dirty
- wr_err  out  1  one-cycle pulse on a write to an unmapped address

## Operation
- Five 8-bit shadow registers, each with a dirty bit. Each maps to one byte of the active outputs.
- **Writes:** wr_valid with wr_addr 0x00–0x04 loads the shadow register and sets its dirty bit. No stall; a write is accepted every cycle.
- **Unmapped writes:** wr_valid with wr_addr ≥ 0x05 changes nothing. wr_err is high the next cycle.
- **Repeated writes:** multiple writes to one address before a commit leave only the last value (last wins).
- **Prescaler:** counts 0..DIV-1. tick = (prescaler == DIV-1). With DIV=1, tick is high every cycle.
- **Period counter:** pwm_cnt increments on tick and wraps 255→0.
- **Boundary:** boundary = (tick && pwm_cnt == 255) || commit_now.
- **Commit:** on a boundary edge, every dirty shadow register is copied to its active byte and all dirty bits are cleared. Clean bytes keep their value.
- **commit_now:** also forces pwm_cnt ← 0 and prescaler ← 0, so the period restarts. If it coincides with a natural wrap, the result is identical to the natural wrap.
- **Write on a boundary edge:** the new wr_data goes to shadow and active together, and that dirty bit ends cleared. The write is committed at this boundary, not the next.
- **Write and commit in the same cycle to other addresses:** committed normally, with no interaction.
- pending = OR of the dirty bits, registered alongside them.
- **State sequence:** IDLE (no dirty bits) → PENDING (≥1 dirty) on a write → IDLE on the boundary commit. A boundary in IDLE still produces period_start but changes no active output.

## Timing
- **Reset values:** en_out = 0x0000, en_pwm_mode = 0x0000, pwm_duty_cycle = 0x00, pwm_cnt = 0x00, period_start = 0, pending = 0, wr_err = 0. Shadows and dirty bits are 0, prescaler is 0.
- **Reset mid-operation:** all outputs return to reset values immediately, and uncommitted shadow data is discarded. First tick comes DIV cycles after rst_n deasserts.
- **Write to shadow:** 1 cycle. pending is high the cycle after the wr_valid edge.
- **Commit latency:** active outputs, pwm_cnt = 0 and period_start = 1 all appear in the same cycle, the one after the boundary edge. pending is low in that cycle.
- **Period length:** 256·DIV cycles. period_start is high exactly 1 cycle per period.
- **Worst-case write-to-active latency:** 256·DIV cycles, or 1 cycle with commit_now.
- **wr_err:** registered, 1 cycle after the offending wr_valid.

## Test plan
- **Reset:** assert rst_n low mid-period with pending = 1 → all outputs at reset values the same cycle. After release, period_start first rises at cycle 256·DIV (DIV=4: 1024).
- **Deferred commit:** DIV=4; write addr 0x04 = 0x80 at pwm_cnt = 0x10 → pwm_duty_cycle stays 0x00 and pending = 1 until the wrap. Then pwm_duty_cycle = 0x80, pwm_cnt = 0, period_start = 1 and pending = 0, all in one cycle.
- **Last wins / partial:** write 0x01 = 0xAA, then 0x01 = 0x55, then 0x02 = 0x0F before a wrap → after the commit, en_out = 0x5500 and en_pwm_mode = 0x000F. The other bytes are unchanged.
- **Boundary collision:** wr_valid addr 0x00 = 0x3C on the exact wrap edge → en_out[7:0] = 0x3C in the period_start cycle, and pending stays 0.
- **Unmapped address:** write addr 0x05 = 0xFF → wr_err pulses 1 cycle. No output changes, pending stays 0.
- **Force commit:** write 0x03 = 0xF0, then commit_now at pwm_cnt = 0x40 → next cycle en_pwm_mode = 0xF000, pwm_cnt = 0 and period_start = 1. The next period_start follows 1024 cycles later.

Source files
------------

// File: rtl/pwm_reg_scheduler.sv
// -----------------------------------------------------------------------------
// pwm_reg_scheduler
//
// Sits between the SPI register-write decode and the PWM output stage.
// Register writes land in five 8-bit shadow registers, each with a dirty bit.
// Dirty shadows are copied to the active configuration only at a PWM period
// boundary, either a natural counter wrap or a forced commit. Because of this,
// the active registers never change in the middle of a period. The block also
// owns the prescaler and the 8-bit period counter that define those boundaries.
//
// Parameters
//   DIV            prescaler ratio; one PWM tick every DIV clk cycles (1..65535)
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   wr_valid       single-cycle write strobe
//   wr_addr[6:0]   0x00 en_out[7:0], 0x01 en_out[15:8], 0x02 en_pwm_mode[7:0],
//                  0x03 en_pwm_mode[15:8], 0x04 pwm_duty_cycle
//   wr_data[7:0]   write data
//   commit_now     single-cycle force-commit request (also restarts the period)
//   en_out         active output-enable register
//   en_pwm_mode    active PWM-mode register
//   pwm_duty_cycle active duty cycle
//   pwm_cnt        PWM period counter
//   period_start   high for the first clk cycle of each period
//   pending        at least one shadow register is dirty
//   wr_err         one-cycle pulse, one cycle after a write to an unmapped address
// -----------------------------------------------------------------------------
module pwm_reg_scheduler #(
  parameter int unsigned DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  input  logic [6:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        commit_now,
  output logic [15:0] en_out,
  output logic [15:0] en_pwm_mode,
  output logic [7:0]  pwm_duty_cycle,
  output logic [7:0]  pwm_cnt,
  output logic        period_start,
  output logic        pending,
  output logic        wr_err
);

  localparam int unsigned NREG     = 5;
  localparam logic [15:0] PRESC_MAX = 16'(DIV - 1);
  localparam logic [7:0]  CNT_MAX   = 8'hFF;
  localparam logic [6:0]  LAST_ADDR = 7'(NREG - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // Timebase state
  logic [15:0] r_presc;
  logic [7:0]  r_cnt;
  logic        r_period_start;

  // Register file: shadow copies, dirty flags, active copies
  logic [7:0]  r_shadow [NREG];
  logic [7:0]  r_active [NREG];
  logic [NREG-1:0] r_dirty;

  logic        r_wr_err;
  state_t      r_state;
  state_t      w_state_nxt;

  logic        w_tick;
  logic        w_wrap;
  logic        w_boundary;
  logic [NREG-1:0] w_wr_hit;
  logic        w_wr_unmapped;

  // ---------------------------------------------------------------------------
  // Timebase decode
  // ---------------------------------------------------------------------------
  assign w_tick     = (r_presc == PRESC_MAX);
  assign w_wrap     = w_tick && (r_cnt == CNT_MAX);
  // A forced commit lands on exactly the same next state as a natural wrap
  // (prescaler and counter both to 0), so the two can simply be OR-ed.
  assign w_boundary = w_wrap || commit_now;

  // ---------------------------------------------------------------------------
  // Write address decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_wr_hit = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      w_wr_hit[i] = wr_valid && (wr_addr == 7'(i));
    end
  end

  assign w_wr_unmapped = wr_valid && (wr_addr > LAST_ADDR);

  // ---------------------------------------------------------------------------
  // Prescaler and period counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc        <= '0;
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= w_boundary;
      if (w_boundary) begin
        r_presc <= '0;
        r_cnt   <= '0;
      end else if (w_tick) begin
        r_presc <= '0;
        r_cnt   <= r_cnt + 8'd1;
      end else begin
        r_presc <= r_presc + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow / active registers
  // A write landing on a boundary edge bypasses straight into the active byte
  // and leaves its dirty bit clear, so it is committed at this boundary rather
  // than lingering until the next one.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_dirty <= '0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (w_wr_hit[i]) begin
          r_shadow[i] <= wr_data;
        end
        if (w_boundary) begin
          if (w_wr_hit[i]) begin
            r_active[i] <= wr_data;
          end else if (r_dirty[i]) begin
            r_active[i] <= r_shadow[i];
          end
          r_dirty[i] <= 1'b0;
        end else if (w_wr_hit[i]) begin
          r_dirty[i] <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Unmapped-write error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= w_wr_unmapped;
    end
  end

  // ---------------------------------------------------------------------------
  // Commit FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Commit FSM: next state
  // Tracks OR of the dirty bits: any boundary empties the shadow set, and a
  // write off a boundary always leaves at least one byte dirty.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_boundary && (|w_wr_hit)) begin
          w_state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (w_boundary) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Commit FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    pending = 1'b0;
    case (r_state)
      ST_IDLE:    pending = 1'b0;
      ST_PENDING: pending = 1'b1;
      default:    pending = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign en_out         = {r_active[1], r_active[0]};
  assign en_pwm_mode    = {r_active[3], r_active[2]};
  assign pwm_duty_cycle = r_active[4];
  assign pwm_cnt        = r_cnt;
  assign period_start   = r_period_start;
  assign wr_err         = r_wr_err;

endmodule

// File: tb/tb_pwm_reg_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for pwm_reg_scheduler (DIV = 4, period = 1024 clk cycles).
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// the same point, i.e. they show the effect of the most recent edge.
// -----------------------------------------------------------------------------
module tb_pwm_reg_scheduler;

  localparam int DIV   = 4;
  localparam int LIMIT = 2000;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        commit_now;
  logic [15:0] en_out;
  logic [15:0] en_pwm_mode;
  logic [7:0]  pwm_duty_cycle;
  logic [7:0]  pwm_cnt;
  logic        period_start;
  logic        pending;
  logic        wr_err;

  int total = 0;
  int bad   = 0;

  pwm_reg_scheduler #(.DIV(DIV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_valid       (wr_valid),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .commit_now     (commit_now),
    .en_out         (en_out),
    .en_pwm_mode    (en_pwm_mode),
    .pwm_duty_cycle (pwm_duty_cycle),
    .pwm_cnt        (pwm_cnt),
    .period_start   (period_start),
    .pending        (pending),
    .wr_err         (wr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input logic [7:0] v, output int n);
    n = 0;
    while (pwm_cnt !== v && n < LIMIT) begin
      step();
      n++;
    end
  endtask

  // Counts edges until period_start is seen high (at least one edge).
  task automatic wait_period_start(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (period_start !== 1'b1 && n < LIMIT);
  endtask

  task automatic write_reg(input logic [6:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; commit_now = 1'b0;
    step(); step();
    total++; if (en_out !== 16'h0000) begin bad++; $display("FAIL reset_en_out got=%h want=0000", en_out); end
    total++; if (en_pwm_mode !== 16'h0000) begin bad++; $display("FAIL reset_mode got=%h want=0000", en_pwm_mode); end
    total++; if (pwm_duty_cycle !== 8'h00) begin bad++; $display("FAIL reset_duty got=%h want=00", pwm_duty_cycle); end
    total++; if (pwm_cnt !== 8'h00) begin bad++; $display("FAIL reset_cnt got=%h want=00", pwm_cnt); end
    total++; if (period_start !== 1'b0) begin bad++; $display("FAIL reset_pstart got=%b want=0", period_start); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b want=0", pending); end
    total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL reset_wr_err got=%b want=0", wr_err); end
    rst_n = 1'b1;
    wait_period_start(n);
    total++; if (n !== 256 * DIV) begin bad++; $display("FAIL first_period got=%0d want=%0d", n, 256 * DIV); end
    total++; if (pwm_cnt !== 8'h00) begin bad++; $display("FAIL first_period_cnt got=%h want=00", pwm_cnt); end
    step();
    total++; if (period_start !== 1'b0) begin bad++; $display("FAIL pstart_width got=%b want=0", period_start); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_deferred_commit();
    int n;
    wait_cnt(8'h10, n);
    total++; if (n >= LIMIT) begin bad++; $display("FAIL defer_wait_10 got=timeout want=cnt 10"); end
    write_reg(7'h04, 8'h80);
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL defer_pending got=%b want=1", pending); end
    total++; if (pwm_duty_cycle !== 8'h00) begin bad++; $display("FAIL defer_duty_early got=%h want=00", pwm_duty_cycle); end
    wait_cnt(8'hFF, n);
    total++; if (pwm_duty_cycle !== 8'h00 || pending !== 1'b1) begin
      bad++; $display("FAIL defer_before_wrap got duty=%h pend=%b want duty=00 pend=1", pwm_duty_cycle, pending);
    end
    wait_period_start(n);
    total++; if (pwm_duty_cycle !== 8'h80) begin bad++; $display("FAIL defer_duty got=%h want=80", pwm_duty_cycle); end
    total++; if (pwm_cnt !== 8'h00) begin bad++; $display("FAIL defer_cnt got=%h want=00", pwm_cnt); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL defer_pending_clr got=%b want=0", pending); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_last_wins();
    int n;
    write_reg(7'h01, 8'hAA);
    write_reg(7'h01, 8'h55);
    write_reg(7'h02, 8'h0F);
    total++; if (en_out !== 16'h0000 || en_pwm_mode !== 16'h0000) begin
      bad++; $display("FAIL lastwin_early got en=%h mode=%h want 0000/0000", en_out, en_pwm_mode);
    end
    wait_period_start(n);
    total++; if (en_out !== 16'h5500) begin bad++; $display("FAIL lastwin_en_out got=%h want=5500", en_out); end
    total++; if (en_pwm_mode !== 16'h000F) begin bad++; $display("FAIL lastwin_mode got=%h want=000F", en_pwm_mode); end
    total++; if (pwm_duty_cycle !== 8'h80) begin bad++; $display("FAIL lastwin_duty got=%h want=80", pwm_duty_cycle); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL lastwin_pending got=%b want=0", pending); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_boundary_collision();
    int n;
    wait_cnt(8'hFF, n);
    // cnt just became 255 with prescaler 0; three more edges bring the
    // prescaler to DIV-1, so the next edge is the wrap edge.
    step(); step(); step();
    write_reg(7'h00, 8'h3C);
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL coll_pstart got=%b want=1", period_start); end
    total++; if (en_out !== 16'h553C) begin bad++; $display("FAIL coll_en_out got=%h want=553C", en_out); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL coll_pending got=%b want=0", pending); end
    total++; if (pwm_cnt !== 8'h00) begin bad++; $display("FAIL coll_cnt got=%h want=00", pwm_cnt); end
    step();
    total++; if (pending !== 1'b0 || period_start !== 1'b0) begin
      bad++; $display("FAIL coll_after got pend=%b pstart=%b want 0/0", pending, period_start);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_unmapped();
    write_reg(7'h05, 8'hFF);
    total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL unmap_err got=%b want=1", wr_err); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL unmap_pending got=%b want=0", pending); end
    total++; if (en_out !== 16'h553C || en_pwm_mode !== 16'h000F || pwm_duty_cycle !== 8'h80) begin
      bad++; $display("FAIL unmap_outputs got en=%h mode=%h duty=%h want 553C/000F/80", en_out, en_pwm_mode, pwm_duty_cycle);
    end
    step();
    total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL unmap_err_width got=%b want=0", wr_err); end
    write_reg(7'h7F, 8'h12);
    total++; if (wr_err !== 1'b1 || pending !== 1'b0) begin
      bad++; $display("FAIL unmap_7f got err=%b pend=%b want 1/0", wr_err, pending);
    end
    write_reg(7'h04, 8'h80);
    total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL mapped_no_err got=%b want=0", wr_err); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_force_commit();
    int n;
    write_reg(7'h03, 8'hF0);
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL force_pending got=%b want=1", pending); end
    wait_cnt(8'h40, n);
    total++; if (en_pwm_mode !== 16'h000F) begin bad++; $display("FAIL force_mode_early got=%h want=000F", en_pwm_mode); end
    commit_now = 1'b1;
    step();
    commit_now = 1'b0;
    total++; if (en_pwm_mode !== 16'hF00F) begin bad++; $display("FAIL force_mode got=%h want=F00F", en_pwm_mode); end
    total++; if (pwm_cnt !== 8'h00) begin bad++; $display("FAIL force_cnt got=%h want=00", pwm_cnt); end
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL force_pstart got=%b want=1", period_start); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL force_pending_clr got=%b want=0", pending); end
    wait_period_start(n);
    total++; if (n !== 256 * DIV) begin bad++; $display("FAIL force_next_period got=%0d want=%0d", n, 256 * DIV); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    int n;
    write_reg(7'h00, 8'h11);
    // write to another address in the same cycle as a forced commit
    wr_valid = 1'b1; wr_addr = 7'h04; wr_data = 8'h22; commit_now = 1'b1;
    step();
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; commit_now = 1'b0;
    total++; if (en_out !== 16'h5511) begin bad++; $display("FAIL b2b_en_out got=%h want=5511", en_out); end
    total++; if (pwm_duty_cycle !== 8'h22) begin bad++; $display("FAIL b2b_duty got=%h want=22", pwm_duty_cycle); end
    total++; if (pending !== 1'b0 || period_start !== 1'b1) begin
      bad++; $display("FAIL b2b_state got pend=%b pstart=%b want 0/1", pending, period_start);
    end
    step(); step();
    // forced commit with nothing dirty: period restarts, outputs hold
    commit_now = 1'b1;
    step();
    commit_now = 1'b0;
    total++; if (period_start !== 1'b1 || pwm_cnt !== 8'h00) begin
      bad++; $display("FAIL idle_commit got pstart=%b cnt=%h want 1/00", period_start, pwm_cnt);
    end
    total++; if (en_out !== 16'h5511 || en_pwm_mode !== 16'hF00F || pwm_duty_cycle !== 8'h22) begin
      bad++; $display("FAIL idle_commit_out got en=%h mode=%h duty=%h want 5511/F00F/22", en_out, en_pwm_mode, pwm_duty_cycle);
    end
    // forced commit coinciding with a natural wrap
    wait_cnt(8'hFF, n);
    step(); step(); step();
    commit_now = 1'b1;
    step();
    commit_now = 1'b0;
    total++; if (period_start !== 1'b1 || pwm_cnt !== 8'h00) begin
      bad++; $display("FAIL wrap_commit got pstart=%b cnt=%h want 1/00", period_start, pwm_cnt);
    end
    wait_period_start(n);
    total++; if (n !== 256 * DIV) begin bad++; $display("FAIL wrap_commit_period got=%0d want=%0d", n, 256 * DIV); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    int n;
    write_reg(7'h01, 8'hEE);
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL rmid_pending_pre got=%b want=1", pending); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (en_out !== 16'h0000 || en_pwm_mode !== 16'h0000 || pwm_duty_cycle !== 8'h00) begin
      bad++; $display("FAIL rmid_outputs got en=%h mode=%h duty=%h want 0000/0000/00", en_out, en_pwm_mode, pwm_duty_cycle);
    end
    total++; if (pending !== 1'b0 || pwm_cnt !== 8'h00 || period_start !== 1'b0 || wr_err !== 1'b0) begin
      bad++; $display("FAIL rmid_ctrl got pend=%b cnt=%h pstart=%b err=%b want 0/00/0/0", pending, pwm_cnt, period_start, wr_err);
    end
    step();
    rst_n = 1'b1;
    wait_period_start(n);
    total++; if (n !== 256 * DIV) begin bad++; $display("FAIL rmid_first_period got=%0d want=%0d", n, 256 * DIV); end
    total++; if (en_out !== 16'h0000) begin bad++; $display("FAIL rmid_discard got=%h want=0000", en_out); end
  endtask

  initial begin
    rst_n      = 1'b0;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    commit_now = 1'b0;
    test_reset();
    test_deferred_commit();
    test_last_wins();
    test_boundary_collision();
    test_unmapped();
    test_force_commit();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
